req_gnt_checker_ip: RTL and testbench
=====================================

# req_gnt_checker_ip

Synthesizable, parametrised request/grant protocol checker. It is the multi-channel successor to the single-channel req/gnt assertion monitor. It checks NUM_CH independent req/gnt pairs against a bounded-latency handshake rule and reports violations as registered error events, per-channel sticky flags and saturating counters. It sits beside arbiter/responder pairs in simulation, emulation and silicon debug builds, and needs no simulator assertion support.

## Interface
Parameters:
- NUM_CH, 4: number of monitored channels (1..32).
- MAX_LAT, 1: maximum number of cycles from req to gnt (1..255). A value of 1 reproduces the original req |=> gnt rule.
- CNT_W, 16: width of the error and pass counters.

Ports:
- clk_ip, in, 1: single clock. All inputs are sampled on its rising edge.
- reset_ip, in, 1: asynchronous, active-low reset.
- en_ip, in, 1: checking enable.
- clr_ip, in, 1: synchronous clear of sticky flags and counters.
- req_ip, in, NUM_CH: request, one bit per channel.
- gnt_ip, in, NUM_CH: grant, one bit per channel.
- err_valid_o, out, 1: single-cycle error event.
- err_ch_o, out, CH_W = max(1, $clog2(NUM_CH)): channel reported with the event.
- err_code_o, out, 2: violation code.
- err_sticky_o, out, NUM_CH: per-channel sticky error flags.
- err_cnt_o, out, CNT_W: saturating count of violations.
- pass_cnt_o, out, CNT_W: saturating count of completed legal handshakes.

## Operation
Each channel runs an independent FSM with states IDLE, WAIT and DONE, plus an 8-bit latency counter k.

IDLE:
- gnt=1 → SPURIOUS_GNT (code 2).
- req=1 → go to WAIT with k=1. This happens even if gnt was also 1 in the same cycle.

WAIT (rules checked in this priority order):
- req=1 → REQ_OVERLAP (code 1), go to IDLE. The overlapping req is not consumed.
- gnt=1 → go to DONE.
- k==MAX_LAT → TIMEOUT (code 0), go to IDLE.
- Otherwise increment k.

DONE (the deassert cycle):
- req|gnt → HOLD (code 3), go to IDLE. A back-to-back req in this cycle is also a violation.
- Otherwise the handshake passes: increment pass_cnt_o and go to IDLE.

Reporting:
- Channel-level error strobes are combined by a reporter.
- err_valid_o is the OR of all strobes.
- err_ch_o and err_code_o come from the lowest-index erroring channel.
- err_sticky_o sets the bit of every erroring channel.
- err_cnt_o adds the popcount of the strobes.

Counters:
- Both counters saturate at all-ones and never wrap.
- If clr_ip=1 in the same cycle as an increment, the clear wins: the counter becomes 0 and the increment is dropped.

Enable:
- When en_ip=0, every FSM is forced to IDLE with k=0.
- No strobes or pass increments are generated.
- Sticky flags and counters hold their values.
- clr_ip still acts.

## Timing
- Reset values: err_valid_o=0, err_ch_o=0, err_code_o=0, err_sticky_o=0, err_cnt_o=0, pass_cnt_o=0. All FSMs are in IDLE with k=0.
- reset_ip low clears every register immediately, without waiting for a clock edge.
- A handshake in progress when reset is asserted is discarded. A gnt arriving after reset is released is reported as SPURIOUS_GNT.
- Latency: a violation sampled at edge t is visible on err_valid_o, err_ch_o and err_code_o after edge t, for exactly one cycle. err_sticky_o and err_cnt_o update at the same edge.
- Pass timing: a clean DONE sample at edge t increments pass_cnt_o after edge t.
- Legal handshake: req for one cycle at edge t. gnt for one cycle at edge t+k, with 1≤k≤MAX_LAT and req=0 for edges t+1..t+k. Then req=0 and gnt=0 at edge t+k+1.
- Channels never interact except through reporter priority and counter accumulation.

## Structure
Shared package req_gnt_chk_pkg holds:
- the state enum (IDLE, WAIT, DONE);
- the err_code enum (TIMEOUT=0, REQ_OVERLAP=1, SPURIOUS_GNT=2, HOLD=3);
- the LAT_W=8 constant.

Sub-module req_gnt_chan_fsm implements one channel's FSM and latency counter. It outputs a single-cycle error strobe, the error code and a pass strobe. The top level instantiates NUM_CH copies in a generate loop and adds the reporter, sticky flags and counters.

## Test plan
- NUM_CH=4, MAX_LAT=1: ch0 req at edge 1, gnt at edge 2, idle at edge 3 → pass_cnt_o=1 after edge 3; err_valid_o stays 0.
- MAX_LAT=3: ch2 req at edge 1, no gnt through edge 4 → after edge 4: err_valid_o=1, err_ch_o=2, err_code_o=0, err_sticky_o=4'b0100, err_cnt_o=1.
- ch1 gnt with no prior req → err_code_o=2, err_ch_o=1. Separately, a gnt held for 2 cycles after a legal req → err_code_o=3.
- In the same cycle, a ch0 timeout and a ch3 spurious gnt → err_ch_o=0, err_code_o=0, err_sticky_o=4'b1001, err_cnt_o incremented by 2.
- CNT_W=2: 5 violations → err_cnt_o saturates at 3. clr_ip pulsed together with a 6th violation → err_cnt_o=0 and err_sticky_o=0.
- reset_ip driven low while ch0 is in WAIT → all outputs are 0 before the next edge. After release, gnt on ch0 → SPURIOUS_GNT reported. With en_ip=0, arbitrary req/gnt traffic → no events and counters unchanged.

Source files
------------

// File: rtl/req_gnt_chk_pkg.sv
// Shared types for the multi-channel request/grant protocol checker.
// Holds the per-channel FSM states, violation codes and latency width.
package req_gnt_chk_pkg;

  localparam int LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    TIMEOUT      = 2'd0,
    REQ_OVERLAP  = 2'd1,
    SPURIOUS_GNT = 2'd2,
    HOLD         = 2'd3
  } err_code_e;

endpackage

// File: rtl/req_gnt_chan_fsm.sv
// One channel of the req/gnt checker: handshake FSM plus latency counter.
// Emits combinational error/pass strobes; registering is done by the top.
module req_gnt_chan_fsm
  import req_gnt_chk_pkg::*;
#(
  parameter int MAX_LAT = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      en_i,
  input  logic      req_i,
  input  logic      gnt_i,
  output logic      err_o,
  output err_code_e code_o,
  output logic      pass_o
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   k_q, k_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_o   = 1'b0;
    code_o  = TIMEOUT;
    pass_o  = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_i) begin
            err_o  = 1'b1;
            code_o = SPURIOUS_GNT;
          end
          // a req is accepted even alongside a spurious gnt
          if (req_i) begin
            state_d = WAIT;
            k_d     = LAT_W'(1);
          end
        end
        WAIT: begin
          if (req_i) begin
            err_o   = 1'b1;
            code_o  = REQ_OVERLAP;
            state_d = IDLE;
            k_d     = '0;
          end else if (gnt_i) begin
            state_d = DONE;
            k_d     = '0;
          end else if (k_q == LAT_W'(MAX_LAT)) begin
            err_o   = 1'b1;
            code_o  = TIMEOUT;
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + LAT_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          k_d     = '0;
          if (req_i || gnt_i) begin
            err_o  = 1'b1;
            code_o = HOLD;
          end else begin
            pass_o = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/req_gnt_checker_ip.sv
// Multi-channel req/gnt protocol checker: per-channel FSMs plus a
// reporter, sticky flags and saturating error/pass counters.
module req_gnt_checker_ip
  import req_gnt_chk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MAX_LAT = 1,
  parameter int CNT_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_ip,
  input  logic              reset_ip,
  input  logic              en_ip,
  input  logic              clr_ip,
  input  logic [NUM_CH-1:0] req_ip,
  input  logic [NUM_CH-1:0] gnt_ip,
  output logic              err_valid_o,
  output logic [CH_W-1:0]   err_ch_o,
  output logic [1:0]        err_code_o,
  output logic [NUM_CH-1:0] err_sticky_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  pass_cnt_o
);

  localparam int POP_W = 6;
  localparam int SUM_W = CNT_W + POP_W;

  logic [NUM_CH-1:0] err_s;
  logic [NUM_CH-1:0] pass_s;
  err_code_e         code_s [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    req_gnt_chan_fsm #(
      .MAX_LAT(MAX_LAT)
    ) u_fsm (
      .clk_i (clk_ip),
      .rst_ni(reset_ip),
      .en_i  (en_ip),
      .req_i (req_ip[g]),
      .gnt_i (gnt_ip[g]),
      .err_o (err_s[g]),
      .code_o(code_s[g]),
      .pass_o(pass_s[g])
    );
  end

  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  err_code_e         code_q, code_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [POP_W-1:0]  err_pop, pass_pop;
  logic [SUM_W-1:0]  esum, psum;

  always_comb begin
    valid_d  = |err_s;
    ch_d     = '0;
    code_d   = TIMEOUT;
    err_pop  = '0;
    pass_pop = '0;
    // walk downwards so the lowest erroring channel wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_s[i]) begin
        ch_d   = CH_W'(i);
        code_d = code_s[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      err_pop  = err_pop + POP_W'(err_s[i]);
      pass_pop = pass_pop + POP_W'(pass_s[i]);
    end
    esum = SUM_W'(ecnt_q) + SUM_W'(err_pop);
    psum = SUM_W'(pcnt_q) + SUM_W'(pass_pop);
    ecnt_d = (|esum[SUM_W-1:CNT_W]) ? '1 : esum[CNT_W-1:0];
    pcnt_d = (|psum[SUM_W-1:CNT_W]) ? '1 : psum[CNT_W-1:0];
    sticky_d = sticky_q | err_s;
    if (clr_ip) begin
      ecnt_d   = '0;
      pcnt_d   = '0;
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk_ip or negedge reset_ip) begin
    if (!reset_ip) begin
      valid_q  <= 1'b0;
      ch_q     <= '0;
      code_q   <= TIMEOUT;
      sticky_q <= '0;
      ecnt_q   <= '0;
      pcnt_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      code_q   <= code_d;
      sticky_q <= sticky_d;
      ecnt_q   <= ecnt_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign err_valid_o  = valid_q;
  assign err_ch_o     = ch_q;
  assign err_code_o   = code_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = ecnt_q;
  assign pass_cnt_o   = pcnt_q;

endmodule

// File: tb/tb_req_gnt_checker_ip.sv
// Scoreboard bench for req_gnt_checker_ip (4 channels, MAX_LAT=3, CNT_W=2).
// Each scenario queues expected outputs per cycle and compares after the edge.
module tb_req_gnt_checker_ip;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
    logic [1:0] code;
    logic [3:0] st;
    logic [1:0] ec;
    logic [1:0] pc;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic [3:0] r;
    logic [3:0] g;
    exp_t       x;
  } stim_t;

  logic       clk_ip = 1'b0;
  logic       reset_ip = 1'b0;
  logic       en_ip = 1'b0;
  logic       clr_ip = 1'b0;
  logic [3:0] req_ip = '0;
  logic [3:0] gnt_ip = '0;
  logic       err_valid_o;
  logic [1:0] err_ch_o;
  logic [1:0] err_code_o;
  logic [3:0] err_sticky_o;
  logic [1:0] err_cnt_o;
  logic [1:0] pass_cnt_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  req_gnt_checker_ip #(
    .NUM_CH (4),
    .MAX_LAT(3),
    .CNT_W  (2)
  ) dut (
    .clk_ip      (clk_ip),
    .reset_ip    (reset_ip),
    .en_ip       (en_ip),
    .clr_ip      (clr_ip),
    .req_ip      (req_ip),
    .gnt_ip      (gnt_ip),
    .err_valid_o (err_valid_o),
    .err_ch_o    (err_ch_o),
    .err_code_o  (err_code_o),
    .err_sticky_o(err_sticky_o),
    .err_cnt_o   (err_cnt_o),
    .pass_cnt_o  (pass_cnt_o)
  );

  always #5 clk_ip = ~clk_ip;

  function automatic exp_t obs();
    return {err_valid_o, err_ch_o, err_code_o,
            err_sticky_o, err_cnt_o, pass_cnt_o};
  endfunction

  function automatic stim_t ent(
    input int e, input int c, input int r, input int g,
    input int v, input int ch, input int code,
    input int st, input int ec, input int pc);
    stim_t s;
    s.en = e[0];
    s.clr = c[0];
    s.r = r[3:0];
    s.g = g[3:0];
    s.x = {v[0], ch[1:0], code[1:0], st[3:0], ec[1:0], pc[1:0]};
    return s;
  endfunction

  task automatic test_reset();
    exp_t got, want;
    reset_ip = 1'b0;
    repeat (2) @(posedge clk_ip);
    #1;
    sb.push_back('0);
    want = sb.pop_front();
    got = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", got, want);
    end
    reset_ip = 1'b1;
    en_ip = 1'b1;
    sb.push_back('0);
    @(posedge clk_ip);
    #1;
    want = sb.pop_front();
    got = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", got, want);
    end
  endtask

  task automatic test_pass();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(ent(1, 0, 2, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(ent(1, 0, 0, 2, 0, 0, 0, 0, 0, 1));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pass[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 1, 2, 0, 4, 1, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 4, 1, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_spurious_hold();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 1, 0));
    t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 2, 1, 0));
    t.push_back(ent(1, 0, 0, 1, 0, 0, 0, 2, 1, 0));
    t.push_back(ent(1, 0, 0, 1, 1, 0, 3, 3, 2, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 3, 2, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL spur_hold[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_overlap();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 4, 0, 1, 2, 1, 4, 1, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 4, 1, 0));
    t.push_back(ent(1, 0, 8, 8, 1, 3, 2, 12, 2, 0));
    t.push_back(ent(1, 0, 0, 8, 0, 0, 0, 12, 2, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 12, 2, 1));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL overlap[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_multi();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 8, 1, 0, 0, 9, 2, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 9, 2, 0));
    t.push_back(ent(1, 0, 0, 15, 1, 0, 2, 15, 3, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 15, 3, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL multi[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 1, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 2, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 3, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 3, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 3, 0));
    t.push_back(ent(1, 1, 0, 2, 1, 1, 2, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturate[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    exp_t got, want;
    int pc;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 1, 0, 1, 0, 3, 1, 1, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    pc = 0;
    for (int n = 0; n < 4; n++) begin
      t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 1, 1, pc));
      t.push_back(ent(1, 0, 0, 1, 0, 0, 0, 1, 1, pc));
      pc = (pc < 3) ? pc + 1 : 3;
      t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 1, 1, pc));
    end
    t.push_back(ent(1, 0, 1, 0, 0, 0, 0, 1, 1, 3));
    t.push_back(ent(1, 0, 0, 1, 0, 0, 0, 1, 1, 3));
    t.push_back(ent(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_enable();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 1, 1, 0, 2, 1, 1, 0));
    t.push_back(ent(1, 0, 4, 0, 0, 0, 0, 1, 1, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_a[%0d] got=%h want=%h", i, got, want);
      end
    end
    for (int i = 0; i < 20; i++) begin
      en_ip = 1'b0;
      clr_ip = 1'b0;
      req_ip = 4'($urandom);
      gnt_ip = 4'($urandom);
      sb.push_back(ent(0, 0, 0, 0, 0, 0, 0, 1, 1, 0).x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_off[%0d] got=%h want=%h", i, got, want);
      end
    end
    t.delete();
    t.push_back(ent(1, 0, 2, 0, 0, 0, 0, 1, 1, 0));
    t.push_back(ent(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 3, 2, 0));
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_b[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_wait();
    stim_t t[$];
    exp_t got, want;
    t.push_back(ent(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(ent(1, 0, 0, 2, 1, 1, 2, 2, 1, 0));
    t.push_back(ent(1, 0, 1, 4, 1, 2, 2, 6, 2, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_pre[%0d] got=%h want=%h", i, got, want);
      end
    end
    req_ip = '0;
    gnt_ip = '0;
    reset_ip = 1'b0;
    sb.push_back('0);
    #2;
    want = sb.pop_front();
    got = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rst_async got=%h want=%h", got, want);
    end
    @(posedge clk_ip);
    #1;
    reset_ip = 1'b1;
    t.delete();
    t.push_back(ent(1, 0, 0, 1, 1, 0, 2, 1, 1, 0));
    t.push_back(ent(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    foreach (t[i]) begin
      en_ip = t[i].en;
      clr_ip = t[i].clr;
      req_ip = t[i].r;
      gnt_ip = t[i].g;
      sb.push_back(t[i].x);
      @(posedge clk_ip);
      #1;
      want = sb.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_post[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_spurious_hold();
    test_overlap();
    test_multi();
    test_saturate();
    test_back_to_back();
    test_enable();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
